// File: rtl/ex_muldiv_unit_if.sv
`timescale 1ns/1ps
// Bundle between the ID/EX stage and the iterative multiply/divide unit.
//
// Handshake: start_in is a request that the unit accepts on the first
// clock edge where it is idle and flush_in is low.  stall_out is the
// back-pressure signal.  While stall_out is high, the pipeline must hold
// the ID/EX register, so start_in, md_op_in and the operands stay put.
// done_out is a one-cycle completion pulse.  HI/LO change on the edge
// that ends that cycle.
interface ex_muldiv_unit_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 flush_in;
  logic                 start_in;
  logic [1:0]           md_op_in;
  logic [BIT_WIDTH-1:0] srcA_in;
  logic [BIT_WIDTH-1:0] srcB_in;
  logic                 hi_we_in;
  logic                 lo_we_in;
  logic [BIT_WIDTH-1:0] wdata_in;
  logic [BIT_WIDTH-1:0] hi_out;
  logic [BIT_WIDTH-1:0] lo_out;
  logic                 busy_out;
  logic                 stall_out;
  logic                 done_out;
  logic                 div0_out;

  modport master (
    output flush_in, start_in, md_op_in, srcA_in, srcB_in,
    output hi_we_in, lo_we_in, wdata_in,
    input  hi_out, lo_out, busy_out, stall_out, done_out, div0_out
  );

  modport slave (
    input  flush_in, start_in, md_op_in, srcA_in, srcB_in,
    input  hi_we_in, lo_we_in, wdata_in,
    output hi_out, lo_out, busy_out, stall_out, done_out, div0_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
`timescale 1ns/1ps
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// State advances on the falling clock edge.  The unit runs operand
// magnitudes through a shift-add multiplier or a restoring divider for
// BIT_WIDTH edges.  It fixes the signs on the commit edge.
module ex_muldiv_unit #(
  parameter int BIT_WIDTH = 32,
  parameter int CNT_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  ex_muldiv_unit_if.slave       md,
  output logic [1:0]            state_dbg
);
  localparam int W = BIT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             start_acc;
  logic             commit;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             sign_a_q, sign_b_q;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   acc_q, acc_step;
  logic [W-1:0]     hi_q, lo_q;
  logic             div0_q;

  logic             in_signed;
  logic [W-1:0]     a_abs, b_abs;
  logic [W:0]       mul_sum, div_rem, div_diff;
  logic             op_signed, op_div, div_by_zero;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     quo, rem;
  logic [W-1:0]     res_hi, res_lo;

  // Control state register; the async reset returns the unit to idle.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and the accept/commit strobes.  Flush wins over everything.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md.start_in && !md.flush_in) begin
          state_d   = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (md.flush_in)                  state_d = IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        commit  = !md.flush_in;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes at accept time; signed ops use two's complement abs.
  always_comb begin
    in_signed = ~md.md_op_in[0];
    a_abs     = (in_signed && md.srcA_in[W-1]) ? -md.srcA_in : md.srcA_in;
    b_abs     = (in_signed && md.srcB_in[W-1]) ? -md.srcB_in : md.srcB_in;
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  // For divide, the upper half of acc holds the partial remainder.  The lower
  // half shifts the dividend out and the quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_rem - {1'b0, b_q};
    if (op_q[1]) begin
      if (div_diff[W]) acc_step = {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
      else             acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
    end
  end

  // Sign correction of the finished magnitude result.  A zero divisor
  // leaves the raw quotient (all ones) and the remainder (the dividend).
  always_comb begin
    op_signed   = ~op_q[0];
    op_div      = op_q[1];
    div_by_zero = op_div && (b_q == '0);
    prod        = (op_signed && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
    quo         = acc_q[W-1:0];
    rem         = acc_q[2*W-1:W];
    res_hi      = prod[2*W-1:W];
    res_lo      = prod[W-1:0];
    if (op_div) begin
      res_lo = quo;
      res_hi = rem;
      if (!div_by_zero && op_signed) begin
        if (sign_a_q ^ sign_b_q) res_lo = -quo;
        if (sign_a_q)            res_hi = -rem;
      end
    end
  end

  // Operand latch at accept time, then one iteration per edge while running.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
    end else if (start_acc) begin
      cnt_q    <= CNT_W'(W);
      op_q     <= md.md_op_in;
      sign_a_q <= in_signed && md.srcA_in[W-1];
      sign_b_q <= in_signed && md.srcB_in[W-1];
      a_q      <= a_abs;
      b_q      <= b_abs;
      acc_q    <= {{W{1'b0}}, (md.md_op_in[1] ? a_abs : b_abs)};
    end else if (state_q == RUN && !md.flush_in) begin
      cnt_q <= cnt_q - CNT_W'(1);
      acc_q <= acc_step;
    end
  end

  // HI/LO and div0: commit results, clear div0 on accept, MTHI/MTLO when idle.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      div0_q <= 1'b0;
    end else if (commit) begin
      hi_q   <= res_hi;
      lo_q   <= res_lo;
      div0_q <= div_by_zero;
    end else if (start_acc) begin
      div0_q <= 1'b0;
    end else if (state_q == IDLE && !md.start_in) begin
      if (md.hi_we_in) hi_q <= md.wdata_in;
      if (md.lo_we_in) lo_q <= md.wdata_in;
    end
  end

  assign md.hi_out    = hi_q;
  assign md.lo_out    = lo_q;
  assign md.div0_out  = div0_q;
  assign md.busy_out  = (state_q != IDLE);
  assign md.stall_out = ((state_q == IDLE) && md.start_in) || (state_q == RUN);
  assign md.done_out  = (state_q == DONE) && !md.flush_in;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
`timescale 1ns/1ps
// Bench for ex_muldiv_unit.  An arithmetic reference model predicts HI/LO,
// div0 and the handshake outputs, and a compare process checks every cycle.
// Directed cases with literal results pin the model itself.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.BIT_WIDTH(W)) md ();

  ex_muldiv_unit #(.BIT_WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .md        (md.slave),
    .state_dbg (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds {div0, hi, lo} for the operation in flight.
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_div0 = 1'b0;
  int           m_left = 0;   // 0 idle, W+1..2 running, 1 completing

  function automatic logic [2*W:0] model_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    longint       sa, sb, p, q, r;
    logic [63:0]  up;
    logic [W-1:0] hi, lo;
    logic         z;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = sa * sb; {hi, lo} = p; end
      2'd1: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
      2'd2: begin
        if (b == 0) begin
          z = 1'b1; lo = '1; hi = a[W-1] ? -a : a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = '0;
        end else begin
          q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin z = 1'b1; lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
    return {z, hi, lo};
  endfunction

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_div0 = 1'b0; m_left = 0;
      exp_q.delete();
    end else if (m_left == 0) begin
      if (md.start_in && !md.flush_in) begin
        exp_q.push_back(model_result(md.md_op_in, md.srcA_in, md.srcB_in));
        m_left = W + 1;
        m_div0 = 1'b0;
      end else if (!md.start_in) begin
        if (md.hi_we_in) m_hi = md.wdata_in;
        if (md.lo_we_in) m_lo = md.wdata_in;
      end
    end else if (md.flush_in) begin
      m_left = 0;
      void'(exp_q.pop_front());
    end else if (m_left == 1) begin
      {m_div0, m_hi, m_lo} = exp_q.pop_front();
      m_left = 0;
    end else begin
      m_left--;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      check("hi",    md.hi_out,    m_hi);
      check("lo",    md.lo_out,    m_lo);
      check("div0",  md.div0_out,  m_div0);
      check("busy",  md.busy_out,  m_left != 0);
      check("stall", md.stall_out, (m_left == 0 && md.start_in) || m_left > 1);
      check("done",  md.done_out,  m_left == 1 && !md.flush_in);
      check("dbg",   state_dbg != 2'd0, m_left != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    md.start_in = 1'b0; md.flush_in = 1'b0; md.hi_we_in = 1'b0; md.lo_we_in = 1'b0;
  endtask

  task automatic mt_write(input bit to_hi, input logic [W-1:0] d);
    @(posedge clk);
    md.hi_we_in = to_hi; md.lo_we_in = !to_hi; md.wdata_in = d;
    @(posedge clk);
    md.hi_we_in = 1'b0; md.lo_we_in = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int stalls, output int dones);
    @(posedge clk);
    md.start_in = 1'b1; md.md_op_in = op; md.srcA_in = a; md.srcB_in = b;
    stalls = 0; dones = 0;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (md.stall_out) stalls++;
      if (md.done_out)  dones++;
      if (i > 0 && !md.busy_out) break;
      @(posedge clk);
      md.start_in = 1'b0;
    end
  endtask

  task automatic random_op();
    int sel, flush_at;
    bit flush_en;
    logic [1:0] op;
    logic [W-1:0] a, b;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      md.hi_we_in = ($urandom_range(0, 3) == 0);
      md.lo_we_in = ($urandom_range(0, 3) == 0);
      md.wdata_in = $urandom;
    end
    sel = $urandom_range(0, 7);
    op  = 2'($urandom_range(0, 3));
    a   = $urandom;
    b   = $urandom;
    if (sel == 0) begin op = 2'd3; b = '0; end
    else if (sel == 1) begin op = 2'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
    else if (sel == 2) begin
      a = W'($urandom_range(0, 40)) - W'(20);
      b = W'($urandom_range(1, 9));
      if ($urandom_range(0, 1) == 1) b = -b;
    end
    flush_en = ($urandom_range(0, 3) == 0);
    flush_at = $urandom_range(0, W + 1);
    @(posedge clk);
    md.start_in = 1'b1; md.md_op_in = op; md.srcA_in = a; md.srcB_in = b;
    md.flush_in = flush_en && flush_at == 0;
    md.hi_we_in = ($urandom_range(0, 3) == 0);
    md.lo_we_in = ($urandom_range(0, 3) == 0);
    md.wdata_in = $urandom;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) begin
        @(posedge clk);
        md.start_in = 1'b0;
        md.flush_in = flush_en && i == flush_at;
        md.hi_we_in = ($urandom_range(0, 3) == 0);
        md.lo_we_in = ($urandom_range(0, 3) == 0);
        md.wdata_in = $urandom;
      end
      #2;
      if (i > 0 && !md.busy_out) break;
    end
    check("rand_idle", md.busy_out, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  int st, dn;

  initial begin
    clear_inputs();
    md.md_op_in = '0; md.srcA_in = '0; md.srcB_in = '0; md.wdata_in = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_hi",   md.hi_out,   '0);
    check("rst_lo",   md.lo_out,   '0);
    check("rst_busy", md.busy_out, 1'b0);
    check("rst_done", md.done_out, 1'b0);
    check("rst_div0", md.div0_out, 1'b0);
    @(posedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // MULTU max * max: latency and one-cycle done
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, dn);
    check("multu_stalls", st, 33);
    check("multu_dones",  dn, 1);
    check("multu_hi", md.hi_out, 32'hFFFF_FFFE);
    check("multu_lo", md.lo_out, 32'h0000_0001);

    // MULT -3 * 7, DIV -7 / 2
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, st, dn);
    check("mult_hi", md.hi_out, 32'hFFFF_FFFF);
    check("mult_lo", md.lo_out, 32'hFFFF_FFEB);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, st, dn);
    check("div_lo", md.lo_out, 32'hFFFF_FFFD);
    check("div_hi", md.hi_out, 32'hFFFF_FFFF);

    // DIVU by zero, then a start clears div0
    run_op(2'd3, 32'd100, 32'd0, st, dn);
    check("div0_lo",   md.lo_out,   32'hFFFF_FFFF);
    check("div0_hi",   md.hi_out,   32'd100);
    check("div0_flag", md.div0_out, 1'b1);
    run_op(2'd1, 32'd2, 32'd3, st, dn);
    check("div0_clr", md.div0_out, 1'b0);
    check("mul6_lo",  md.lo_out,   32'd6);

    // signed overflow divide
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, st, dn);
    check("ovf_lo", md.lo_out, 32'h8000_0000);
    check("ovf_hi", md.hi_out, 32'h0);

    // flush mid-run keeps MTHI/MTLO values
    mt_write(1'b1, 32'hAAAA_5555);
    mt_write(1'b0, 32'h0BAD_F00D);
    @(posedge clk);
    md.start_in = 1'b1; md.md_op_in = 2'd1; md.srcA_in = 32'd5; md.srcB_in = 32'd6;
    dn = 0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      md.start_in = 1'b0;
      md.flush_in = (i == 11);
      #2;
      if (md.done_out) dn++;
    end
    @(posedge clk);
    md.flush_in = 1'b0;
    #2;
    check("flush_busy", md.busy_out, 1'b0);
    check("flush_hi",   md.hi_out,   32'hAAAA_5555);
    check("flush_lo",   md.lo_out,   32'h0BAD_F00D);
    check("flush_done", dn, 0);

    // MTLO in idle, MTHI during RUN dropped, reset mid-run
    mt_write(1'b0, 32'h0000_1234);
    #2;
    check("mtlo", md.lo_out, 32'h0000_1234);
    @(posedge clk);
    md.start_in = 1'b1; md.md_op_in = 2'd1; md.srcA_in = 32'd3; md.srcB_in = 32'd4;
    @(posedge clk);
    md.start_in = 1'b0;
    md.hi_we_in = 1'b1; md.wdata_in = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    md.hi_we_in = 1'b0;
    #2;
    check("mthi_run_hi",   md.hi_out,   32'hAAAA_5555);
    check("mthi_run_busy", md.busy_out, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rrst_hi",    md.hi_out,    '0);
    check("rrst_lo",    md.lo_out,    '0);
    check("rrst_busy",  md.busy_out,  1'b0);
    check("rrst_stall", md.stall_out, 1'b0);
    @(posedge clk);
    rst = 1'b1;

    // randomized traffic against the model
    repeat (40) random_op();

    @(posedge clk);
    clear_inputs();
    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
